// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates on issue, completes on writeback,
// retires the head into the register file. Optional ROB_BYPASS_EN forwards writeback to lookups.
module reorder_buffer #(
  parameter int ROB_WIDTH = 3,
  parameter int REG_WIDTH = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,

  input  logic                 issue_valid,
  input  logic [REG_WIDTH-1:0] issue_reg_id,
  output logic                 issue_ready,
  output logic [ROB_WIDTH-1:0] issue_rob_id,

  input  logic                 wb_valid,
  input  logic [ROB_WIDTH-1:0] wb_rob_id,
  input  logic [31:0]          wb_data,
  input  logic                 wb_mispredict,
  input  logic [31:0]          wb_redirect_pc,

  output logic [REG_WIDTH-1:0] commit_reg_id,
  output logic [31:0]          commit_data,
  output logic [ROB_WIDTH-1:0] commit_rob_id,

  input  logic [ROB_WIDTH-1:0] rob_rob_id_j,
  input  logic [ROB_WIDTH-1:0] rob_rob_id_k,
  output logic                 rob_ready_j,
  output logic                 rob_ready_k,
  output logic [31:0]          rob_data_j,
  output logic [31:0]          rob_data_k,

  output logic                 flush,
  output logic [31:0]          flush_pc
);

  localparam int SIZE = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH + 1)'(SIZE);

  logic [SIZE-1:0]      busy_q, busy_d;
  logic [SIZE-1:0]      ready_q, ready_d;
  logic [SIZE-1:0]      mispredict_q, mispredict_d;
  logic [REG_WIDTH-1:0] regId_q [SIZE];
  logic [REG_WIDTH-1:0] regId_d [SIZE];
  logic [31:0]          data_q [SIZE];
  logic [31:0]          data_d [SIZE];
  logic [31:0]          redirectPc_q [SIZE];
  logic [31:0]          redirectPc_d [SIZE];

  logic [ROB_WIDTH-1:0] head_q, head_d;
  logic [ROB_WIDTH-1:0] tail_q, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;

  logic [REG_WIDTH-1:0] commitRegId_q, commitRegId_d;
  logic [31:0]          commitData_q, commitData_d;
  logic [ROB_WIDTH-1:0] commitRobId_q, commitRobId_d;
  logic                 flush_q, flush_d;
  logic [31:0]          flushPc_q, flushPc_d;

  logic doIssue;
  logic doWriteback;
  logic doCommit;

  assign issue_ready  = (count_q != FULL_COUNT) && !flush_q;
  assign issue_rob_id = tail_q;

  assign doIssue     = issue_valid && issue_ready;
  assign doWriteback = wb_valid && !flush_q && busy_q[wb_rob_id];
  assign doCommit    = busy_q[head_q] && ready_q[head_q];

  assign commit_reg_id = commitRegId_q;
  assign commit_data   = commitData_q;
  assign commit_rob_id = commitRobId_q;
  assign flush         = flush_q;
  assign flush_pc      = flushPc_q;

  always_comb begin
    busy_d        = busy_q;
    ready_d       = ready_q;
    mispredict_d  = mispredict_q;
    regId_d       = regId_q;
    data_d        = data_q;
    redirectPc_d  = redirectPc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    commitRegId_d = '0;
    commitData_d  = commitData_q;
    commitRobId_d = commitRobId_q;
    flush_d       = 1'b0;
    flushPc_d     = flushPc_q;

    if (doWriteback) begin
      ready_d[wb_rob_id]      = 1'b1;
      data_d[wb_rob_id]       = wb_data;
      mispredict_d[wb_rob_id] = wb_mispredict;
      redirectPc_d[wb_rob_id] = wb_redirect_pc;
    end

    if (doIssue) begin
      busy_d[tail_q]       = 1'b1;
      ready_d[tail_q]      = 1'b0;
      mispredict_d[tail_q] = 1'b0;
      regId_d[tail_q]      = issue_reg_id;
      tail_d               = tail_q + 1'b1;
    end

    if (doCommit) begin
      commitRegId_d  = regId_q[head_q];
      commitData_d   = data_q[head_q];
      commitRobId_d  = head_q;
      busy_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
    end

    // Mispredicted head still retires its link value, but wipes every younger entry.
    if (doCommit && mispredict_q[head_q]) begin
      flush_d   = 1'b1;
      flushPc_d = redirectPc_q[head_q];
      busy_d    = '0;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
    end else begin
      case ({doIssue, doCommit})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q        <= '0;
      ready_q       <= '0;
      mispredict_q  <= '0;
      for (int i = 0; i < SIZE; i++) begin
        regId_q[i]      <= '0;
        data_q[i]       <= '0;
        redirectPc_q[i] <= '0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commitRegId_q <= '0;
      commitData_q  <= '0;
      commitRobId_q <= '0;
      flush_q       <= 1'b0;
      flushPc_q     <= '0;
    end else if (rdy_in) begin
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      mispredict_q  <= mispredict_d;
      regId_q       <= regId_d;
      data_q        <= data_d;
      redirectPc_q  <= redirectPc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commitRegId_q <= commitRegId_d;
      commitData_q  <= commitData_d;
      commitRobId_q <= commitRobId_d;
      flush_q       <= flush_d;
      flushPc_q     <= flushPc_d;
    end
  end

  // Operand lookups read stored state; the bypass build also forwards the live writeback.
  always_comb begin
    rob_ready_j = busy_q[rob_rob_id_j] && ready_q[rob_rob_id_j];
    rob_data_j  = data_q[rob_rob_id_j];
    rob_ready_k = busy_q[rob_rob_id_k] && ready_q[rob_rob_id_k];
    rob_data_k  = data_q[rob_rob_id_k];
`ifdef ROB_BYPASS_EN
    if (wb_valid && !flush_q && (wb_rob_id == rob_rob_id_j) && busy_q[rob_rob_id_j]) begin
      rob_ready_j = 1'b1;
      rob_data_j  = wb_data;
    end
    if (wb_valid && !flush_q && (wb_rob_id == rob_rob_id_k) && busy_q[rob_rob_id_k]) begin
      rob_ready_k = 1'b1;
      rob_data_k  = wb_data;
    end
`endif
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: issue, writeback, commit,
// mispredict flush, wrap-around, lookups and the rdy_in freeze.
module tb_reorder_buffer;

`ifdef ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        issue_valid;
  logic [4:0]  issue_reg_id;
  logic        issue_ready;
  logic [2:0]  issue_rob_id;
  logic        wb_valid;
  logic [2:0]  wb_rob_id;
  logic [31:0] wb_data;
  logic        wb_mispredict;
  logic [31:0] wb_redirect_pc;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_data;
  logic [2:0]  commit_rob_id;
  logic [2:0]  rob_rob_id_j;
  logic [2:0]  rob_rob_id_k;
  logic        rob_ready_j;
  logic        rob_ready_k;
  logic [31:0] rob_data_j;
  logic [31:0] rob_data_k;
  logic        flush;
  logic [31:0] flush_pc;

  int passCount = 0;
  int failCount = 0;
  int totalCount = 0;

  reorder_buffer #(.ROB_WIDTH(3), .REG_WIDTH(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_reg_id(issue_reg_id),
    .issue_ready(issue_ready), .issue_rob_id(issue_rob_id),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_data(wb_data),
    .wb_mispredict(wb_mispredict), .wb_redirect_pc(wb_redirect_pc),
    .commit_reg_id(commit_reg_id), .commit_data(commit_data), .commit_rob_id(commit_rob_id),
    .rob_rob_id_j(rob_rob_id_j), .rob_rob_id_k(rob_rob_id_k),
    .rob_ready_j(rob_ready_j), .rob_ready_k(rob_ready_k),
    .rob_data_j(rob_data_j), .rob_data_k(rob_data_k),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [4:0] ireg,
                               input logic wv, input logic [2:0] wid, input logic [31:0] wdat,
                               input logic wmis, input logic [31:0] wpc);
    issue_valid    = iv;
    issue_reg_id   = ireg;
    wb_valid       = wv;
    wb_rob_id      = wid;
    wb_data        = wdat;
    wb_mispredict  = wmis;
    wb_redirect_pc = wpc;
  endtask

  task automatic stepClock();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulseReset();
    rst_in = 1'b1;
    #2;
    rst_in = 1'b0;
    #1;
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    rob_rob_id_j = '0;
    rob_rob_id_k = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #12;
    rst_in = 1'b0;
    #1;

    // Reset state
    checkOutput("reset issue_ready", 32'(issue_ready), 1);
    checkOutput("reset issue_rob_id", 32'(issue_rob_id), 0);
    checkOutput("reset commit_reg_id", 32'(commit_reg_id), 0);
    checkOutput("reset commit_data", commit_data, 0);
    checkOutput("reset flush", 32'(flush), 0);
    checkOutput("reset flush_pc", flush_pc, 0);

    // Fill all eight entries with no writebacks
    for (int i = 0; i < 8; i++) begin
      checkOutput("fill issue_rob_id", 32'(issue_rob_id), 32'(i));
      checkOutput("fill issue_ready", 32'(issue_ready), 1);
      applyStimulus(1, 5'(i + 1), 0, 0, 0, 0, 0);
      stepClock();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("full issue_ready", 32'(issue_ready), 0);
    checkOutput("full issue_rob_id wraps", 32'(issue_rob_id), 0);
    checkOutput("full no commit", 32'(commit_reg_id), 0);
    rob_rob_id_j = 3'd3;
    #1;
    checkOutput("lookup not ready", 32'(rob_ready_j), 0);

    // Asynchronous reset mid-operation empties the queue at once
    pulseReset();
    checkOutput("async reset issue_ready", 32'(issue_ready), 1);
    checkOutput("async reset issue_rob_id", 32'(issue_rob_id), 0);

    // Single issue / writeback / commit
    applyStimulus(1, 5, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(0, 0, 1, 0, 32'hDEADBEEF, 0, 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("single pre-commit reg", 32'(commit_reg_id), 0);
    stepClock();
    checkOutput("single commit reg", 32'(commit_reg_id), 5);
    checkOutput("single commit data", commit_data, 32'hDEADBEEF);
    checkOutput("single commit rob_id", 32'(commit_rob_id), 0);
    stepClock();
    checkOutput("single commit one cycle", 32'(commit_reg_id), 0);
    checkOutput("single next tail", 32'(issue_rob_id), 1);

    // Out-of-order completion with lookups and optional bypass
    pulseReset();
    applyStimulus(1, 3, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(1, 4, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(0, 0, 1, 1, 32'h11, 0, 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("ooo no commit a", 32'(commit_reg_id), 0);
    stepClock();
    checkOutput("ooo no commit b", 32'(commit_reg_id), 0);
    rob_rob_id_j = 3'd0;
    rob_rob_id_k = 3'd1;
    applyStimulus(0, 0, 1, 0, 32'h42, 0, 0);
    #1;
    checkOutput("bypass ready_j", 32'(rob_ready_j), BYP ? 32'd1 : 32'd0);
    checkOutput("bypass data_j", rob_data_j, BYP ? 32'h42 : 32'h0);
    checkOutput("lookup ready_k", 32'(rob_ready_k), 1);
    checkOutput("lookup data_k", rob_data_k, 32'h11);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("ooo no commit c", 32'(commit_reg_id), 0);
    checkOutput("lookup ready_j later", 32'(rob_ready_j), 1);
    checkOutput("lookup data_j later", rob_data_j, 32'h42);
    stepClock();
    checkOutput("ooo commit0 reg", 32'(commit_reg_id), 3);
    checkOutput("ooo commit0 data", commit_data, 32'h42);
    checkOutput("ooo commit0 rob_id", 32'(commit_rob_id), 0);
    stepClock();
    checkOutput("ooo commit1 reg", 32'(commit_reg_id), 4);
    checkOutput("ooo commit1 data", commit_data, 32'h11);
    checkOutput("ooo commit1 rob_id", 32'(commit_rob_id), 1);
    stepClock();
    checkOutput("ooo drained", 32'(commit_reg_id), 0);

    // Mispredicted head with three younger busy entries
    pulseReset();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 5'(i), 0, 0, 0, 0, 0);
      stepClock();
    end
    applyStimulus(0, 0, 1, 0, 32'h55, 1, 32'h100);
    stepClock();
    checkOutput("mis pre flush", 32'(flush), 0);
    applyStimulus(1, 9, 1, 1, 32'h66, 0, 0);
    stepClock();
    checkOutput("mis flush", 32'(flush), 1);
    checkOutput("mis flush_pc", flush_pc, 32'h100);
    checkOutput("mis link commit reg", 32'(commit_reg_id), 1);
    checkOutput("mis link commit data", commit_data, 32'h55);
    checkOutput("mis link commit rob_id", 32'(commit_rob_id), 0);
    checkOutput("mis flush issue_ready", 32'(issue_ready), 0);
    checkOutput("mis flush issue_rob_id", 32'(issue_rob_id), 0);
    applyStimulus(1, 10, 1, 0, 32'h77, 0, 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("mis flush drops", 32'(flush), 0);
    checkOutput("mis after issue_ready", 32'(issue_ready), 1);
    checkOutput("mis after issue_rob_id", 32'(issue_rob_id), 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("mis younger never commit", 32'(commit_reg_id), 0);
      stepClock();
    end

    // Wrap-around: 20 pipelined issue/writeback/commit triples
    pulseReset();
    for (int t = 0; t < 23; t++) begin
      if (t < 20) checkOutput("wrap issue_ready", 32'(issue_ready), 1);
      applyStimulus(t < 20, 5'((t % 7) + 1),
                    (t >= 1) && (t <= 20), 3'((t - 1) % 8), 32'h1000 + 32'(t - 1), 0, 0);
      stepClock();
      if (t >= 2 && t <= 21) begin
        checkOutput("wrap commit_rob_id", 32'(commit_rob_id), 32'((t - 2) % 8));
        checkOutput("wrap commit_reg_id", 32'(commit_reg_id), 32'(((t - 2) % 7) + 1));
        checkOutput("wrap commit_data", commit_data, 32'h1000 + 32'(t - 2));
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap drained", 32'(commit_reg_id), 0);
    checkOutput("wrap tail", 32'(issue_rob_id), 4);

    // rdy_in low freezes state
    rdy_in = 1'b0;
    applyStimulus(1, 7, 0, 0, 0, 0, 0);
    stepClock();
    checkOutput("freeze tail held", 32'(issue_rob_id), 4);
    rdy_in = 1'b1;
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("unfreeze tail advances", 32'(issue_rob_id), 5);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
